// File: rtl/halflife_sequencer_if.sv
// Handshake, configuration and status bundle between a host and halflife_sequencer.
// The host drives commands and config; the sequencer drives counter-load and status.
interface halflife_sequencer_if #(
  parameter int N = 4,
  parameter int P = 8,
  parameter int H = 8
);
  logic         start;
  logic         pause;
  logic         abort;
  logic [N-1:0] init_qty;
  logic [P-1:0] prescale;
  logic [H-1:0] half_period;
  logic [N-1:0] threshold;
  logic         cnt_load;
  logic [N-1:0] cnt_in;
  logic [N-1:0] qty;
  logic [N-1:0] halvings;
  logic         tick;
  logic         busy;
  logic         done;

  modport master (
    output start, pause, abort, init_qty, prescale, half_period, threshold,
    input  cnt_load, cnt_in, qty, halvings, tick, busy, done
  );

  modport slave (
    input  start, pause, abort, init_qty, prescale, half_period, threshold,
    output cnt_load, cnt_in, qty, halvings, tick, busy, done
  );
endinterface

// File: rtl/halflife_sequencer.sv
// Radioactive-decay sequencer: loads a quantity into the external counter and halves it
// once per half-life (measured in prescaled ticks) until it reaches the threshold.
module halflife_sequencer #(
  parameter int N = 4,
  parameter int P = 8,
  parameter int H = 8
) (
  input logic clk,
  input logic rst,
  halflife_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [N-1:0] ZERO_N = {N{1'b0}};
  localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] ALL_N  = {N{1'b1}};
  localparam logic [P-1:0] ZERO_P = {P{1'b0}};
  localparam logic [P-1:0] ONE_P  = {{(P-1){1'b0}}, 1'b1};
  localparam logic [H-1:0] ZERO_H = {H{1'b0}};
  localparam logic [H-1:0] ONE_H  = {{(H-1){1'b0}}, 1'b1};

  state_t       state_r;
  logic [N-1:0] qty_r, halvings_r, cnt_in_r, threshold_r;
  logic [P-1:0] presc_r, prescale_r;
  logic [H-1:0] per_cnt_r, half_period_r;
  logic         cnt_load_r, busy_r, done_r;

  logic         tick_s;
  logic         halve_s;
  logic [H-1:0] last_cnt_s;
  logic [N-1:0] half_qty_s;

  // A captured half_period of 0 behaves as 1, so the last count is 0 in both cases
  assign last_cnt_s = (half_period_r == ZERO_H) ? ZERO_H : (half_period_r - ONE_H);
  assign tick_s     = (state_r == RUN) && (presc_r == prescale_r);
  assign halve_s    = tick_s && (per_cnt_r == last_cnt_s);
  assign half_qty_s = {1'b0, qty_r[N-1:1]};

  assign bus.tick     = tick_s;
  assign bus.cnt_load = cnt_load_r;
  assign bus.cnt_in   = cnt_in_r;
  assign bus.qty      = qty_r;
  assign bus.halvings = halvings_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  // Sequencer FSM with priority rst > abort > start > pause > timing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      qty_r         <= ZERO_N;
      halvings_r    <= ZERO_N;
      cnt_in_r      <= ZERO_N;
      threshold_r   <= ZERO_N;
      presc_r       <= ZERO_P;
      prescale_r    <= ZERO_P;
      per_cnt_r     <= ZERO_H;
      half_period_r <= ZERO_H;
      cnt_load_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else if (bus.abort) begin
      state_r    <= IDLE;
      qty_r      <= ZERO_N;
      halvings_r <= ZERO_N;
      presc_r    <= ZERO_P;
      per_cnt_r  <= ZERO_H;
      cnt_load_r <= 1'b1;
      cnt_in_r   <= ZERO_N;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else if (bus.start && ((state_r == IDLE) || (state_r == DONE))) begin
      prescale_r    <= bus.prescale;
      half_period_r <= bus.half_period;
      threshold_r   <= bus.threshold;
      qty_r         <= bus.init_qty;
      halvings_r    <= ZERO_N;
      presc_r       <= ZERO_P;
      per_cnt_r     <= ZERO_H;
      cnt_load_r    <= 1'b1;
      cnt_in_r      <= bus.init_qty;
      if (bus.init_qty <= bus.threshold) begin
        state_r <= DONE;
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
      end else begin
        state_r <= RUN;
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
      end
    end else begin
      cnt_load_r <= 1'b0;
      case (state_r)
        RUN: begin
          // Timing advances even when pause is sampled; pause only picks the next state
          if (halve_s) begin
            presc_r    <= ZERO_P;
            per_cnt_r  <= ZERO_H;
            qty_r      <= half_qty_s;
            halvings_r <= (halvings_r == ALL_N) ? halvings_r : (halvings_r + ONE_N);
            cnt_load_r <= 1'b1;
            cnt_in_r   <= half_qty_s;
          end else if (tick_s) begin
            presc_r   <= ZERO_P;
            per_cnt_r <= per_cnt_r + ONE_H;
          end else begin
            presc_r <= presc_r + ONE_P;
          end
          if (halve_s && (half_qty_s <= threshold_r)) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (bus.pause) begin
            state_r <= PAUSED;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        PAUSED: begin
          if (bus.pause) begin
            state_r <= PAUSED;
          end else begin
            state_r <= RUN;
          end
          busy_r <= 1'b1;
          done_r <= 1'b0;
        end
        IDLE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        DONE: begin
          state_r <= DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_halflife_sequencer.sv
// Directed bench for halflife_sequencer: a table of whole-run scenarios plus
// cycle-exact sequences for nominal decay, abort, pause and reset.
module tb_halflife_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  halflife_sequencer_if #(.N(4), .P(8), .H(8)) bus ();
  halflife_sequencer #(.N(4), .P(8), .H(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] init;
    logic [7:0] pre;
    logic [7:0] hp;
    logic [3:0] thr;
    int         done_cyc;
    logic [3:0] qty;
    logic [3:0] halv;
    int         loads;
    int         ticks;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic arm(input logic [3:0] init, input logic [7:0] pre, input logic [7:0] hp,
                     input logic [3:0] thr);
    bus.init_qty    = init;
    bus.prescale    = pre;
    bus.half_period = hp;
    bus.threshold   = thr;
    bus.start       = 1'b1;
  endtask

  initial begin
    int loads;
    int ticks;
    int dc;
    int tk;
    logic       e_load;
    logic       e_tick;
    logic [3:0] e_qty;
    logic       e_done;

    vecs[0] = '{4'd12, 8'd1, 8'd2, 4'd1, 13, 4'd1, 4'd3, 4, 6};
    vecs[1] = '{4'd2,  8'd1, 8'd2, 4'd3, 1,  4'd2, 4'd0, 1, 0};
    vecs[2] = '{4'd15, 8'd0, 8'd0, 4'd0, 5,  4'd0, 4'd4, 5, 4};
    vecs[3] = '{4'd8,  8'd0, 8'd3, 4'd0, 13, 4'd0, 4'd4, 5, 12};
    vecs[4] = '{4'd9,  8'd2, 8'd1, 4'd4, 4,  4'd4, 4'd1, 2, 1};
    vecs[5] = '{4'd15, 8'd3, 8'd2, 4'd7, 9,  4'd7, 4'd1, 2, 2};

    rst = 1'b1;
    bus.start = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0;
    bus.init_qty = 4'd0; bus.prescale = 8'd0; bus.half_period = 8'd0; bus.threshold = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state", {bus.qty, bus.halvings, bus.cnt_in, bus.cnt_load, bus.tick, bus.busy, bus.done},
          {4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});

    // Nominal decay, cycle by cycle: 12 -> 6 -> 3 -> 1
    arm(4'd12, 8'd1, 8'd2, 4'd1);
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      e_load = ((c % 4) == 1);
      e_tick = ((c % 2) == 0) && (c < 13);
      e_qty  = 4'(12 >> ((c - 1) / 4));
      e_done = (c == 13);
      check($sformatf("nominal_c%0d", c), {bus.cnt_load, bus.tick, bus.qty, bus.done, bus.busy},
            {e_load, e_tick, e_qty, e_done, ~e_done});
      if (e_load) check($sformatf("nominal_cnt_in_c%0d", c), {28'd0, bus.cnt_in}, {28'd0, e_qty});
    end
    check("nominal_halvings", {28'd0, bus.halvings}, 32'd3);

    // Restart from DONE, ignored start in RUN, abort in cycle 6
    arm(4'd12, 8'd1, 8'd2, 4'd1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1
      bus.start = (c == 3);
      bus.abort = (c == 6);
      @(negedge clk);
      if (c == 1) check("restart_from_done", {bus.cnt_load, bus.busy, bus.done}, {1'b1, 1'b1, 1'b0});
      if (c == 4) check("start_ignored", {bus.cnt_load, bus.qty}, {1'b0, 4'd12});
      if (c == 5) check("halving_after_ignored_start", {bus.cnt_load, bus.cnt_in, bus.halvings}, {1'b1, 4'd6, 4'd1});
      if (c == 7) check("abort_clear", {bus.cnt_load, bus.cnt_in, bus.qty, bus.halvings, bus.busy, bus.done},
                        {1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0});
      if (c == 8) check("abort_idle", {bus.cnt_load, bus.tick, bus.busy}, {1'b0, 1'b0, 1'b0});
    end
    bus.abort = 1'b0;

    // Pause high in cycles 3..10 postpones the first halving to cycle 12
    arm(4'd12, 8'd1, 8'd2, 4'd1);
    tk = 0;
    dc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1
      bus.start = 1'b0;
      bus.pause = (c >= 3) && (c <= 10);
      @(negedge clk);
      if ((c >= 3) && (c <= 11) && bus.tick) tk++;
      if (c == 8)  check("pause_busy", {bus.busy, bus.done, bus.cnt_load}, {1'b1, 1'b0, 1'b0});
      if (c == 12) check("pause_first_halving_tick", {31'd0, bus.tick}, 32'd1);
      if (c == 13) check("pause_first_load", {bus.cnt_load, bus.cnt_in, bus.qty}, {1'b1, 4'd6, 4'd6});
      if (bus.done && (dc == 0)) dc = c;
    end
    check("pause_no_ticks", tk, 32'd0);
    check("pause_done_cycle", dc, 32'd21);
    check("pause_final", {bus.qty, bus.halvings}, {4'd1, 4'd3});

    // Whole-run scenarios, each started from the previous DONE state
    for (int i = 0; i < 6; i++) begin
      arm(vecs[i].init, vecs[i].pre, vecs[i].hp, vecs[i].thr);
      loads = 0;
      ticks = 0;
      dc = 0;
      for (int c = 1; c <= 200; c++) begin
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        if (bus.cnt_load) loads++;
        if (bus.tick) ticks++;
        if (bus.done) begin
          dc = c;
          break;
        end
      end
      check($sformatf("vec%0d_done_cycle", i), dc, vecs[i].done_cyc);
      check($sformatf("vec%0d_qty", i), {28'd0, bus.qty}, {28'd0, vecs[i].qty});
      check($sformatf("vec%0d_halvings", i), {28'd0, bus.halvings}, {28'd0, vecs[i].halv});
      check($sformatf("vec%0d_loads", i), loads, vecs[i].loads);
      check($sformatf("vec%0d_ticks", i), ticks, vecs[i].ticks);
    end

    // Synchronous reset in the middle of a run
    arm(4'd12, 8'd1, 8'd2, 4'd1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1 bus.start = 1'b0;
    end
    @(negedge clk);
    check("midrun_before_reset", {bus.qty, bus.busy}, {4'd6, 1'b1});
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrun_reset", {bus.qty, bus.halvings, bus.cnt_load, bus.tick, bus.busy, bus.done},
          {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    check("midrun_reset_stays_idle", {bus.qty, bus.cnt_load, bus.tick, bus.busy}, {4'd0, 1'b0, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/halflife_sequencer.md
Name: halflife_sequencer

Overview:
- Controller that sequences the team's 4-bit load/up/down counter as a radioactive-decay display.
- Loads an initial quantity, then halves it once per programmable half-life period and reloads the counter at each halving.
- The half-life period is measured in prescaled clock ticks.
- Stops when the quantity falls to or below a threshold; supports pause and abort.

Parameters:
- N, 4, width of quantity, threshold, counter data and halvings count
- P, 8, width of prescale value and prescaler counter
- H, 8, width of half_period value and period counter

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin sequence; honoured only in IDLE or DONE
- pause  input  1  level; freezes timing while high in RUN
- abort  input  1  pulse; return to IDLE from any state
- init_qty  input  N  starting quantity, sampled on accepted start
- prescale  input  P  tick every prescale+1 cycles, sampled on start
- half_period  input  H  ticks per half-life, sampled on start; 0 treated as 1
- threshold  input  N  completion level, sampled on start
- cnt_load  output  1  one-cycle load strobe to counter
- cnt_in  output  N  value to load, valid while cnt_load=1
- qty  output  N  current remaining quantity
- halvings  output  N  half-lives elapsed, saturating at all-ones
- tick  output  1  prescaler tick, combinational decode (RUN and presc==prescale)
- busy  output  1  high in RUN or PAUSED
- done  output  1  high in DONE

Behaviour:
- Reset (rst=1 at edge):
  - State IDLE.
  - qty, halvings, cnt_in, presc, per_cnt, captured config = 0.
  - cnt_load=0, busy=0, done=0.
  - rst overrides all other inputs.
- Priority per edge: rst > abort > start > pause > timing.
- States: IDLE, RUN, PAUSED, DONE. All outputs registered except tick.
- IDLE/DONE + start:
  - Capture config; qty<=init_qty; halvings<=0; presc<=0; per_cnt<=0.
  - cnt_load<=1, cnt_in<=init_qty.
  - Next state DONE if init_qty<=threshold, else RUN.
- start while RUN/PAUSED: ignored.
- RUN:
  - presc increments each cycle; when presc==prescale, tick=1 and presc<=0.
  - On tick, per_cnt increments. When per_cnt==eff_period-1 on a tick, that is a halving event:
    - per_cnt<=0; qty<=qty>>1 (logical); halvings<=halvings+1, saturating at 2^N-1.
    - cnt_load<=1, cnt_in<=qty>>1.
    - If (qty>>1)<=threshold, next state DONE.
  - eff_period = max(half_period,1).
- RUN + pause=1: next state PAUSED. presc and per_cnt hold; no tick in PAUSED. pause=0 returns to RUN and counting resumes from the held values.
- pause in the same cycle as a tick: the tick and any halving in that cycle complete, then PAUSED.
- cnt_load is high for exactly one cycle per load, and 0 otherwise.
- abort:
  - Any state to IDLE; presc, per_cnt, halvings <= 0; qty <= 0.
  - cnt_load<=1, cnt_in<=0 (clears the counter).
  - No effect beyond this when already in IDLE with qty=0.
- DONE:
  - qty and halvings hold; done=1; stays until start or abort.
  - start in DONE restarts immediately with no IDLE visit.
- Timing: start accepted at edge 0 (RUN from cycle 1). The k-th halving event (tick high) occurs in cycle k*eff_period*(prescale+1); qty updates at the following edge.
- qty=0 with threshold=0 ends the sequence; qty never underflows because shift only.
- Config inputs may change freely during RUN; captured copies are used.

Test Plan:
- Reset: drive rst mid-RUN -> next cycle state IDLE, qty=0, halvings=0, busy=0, done=0, cnt_load=0.
- Nominal: init_qty=12, prescale=1, half_period=2, threshold=1, start at cycle 0.
  - Response: halving events in cycles 4, 8, 12; qty 12->6->3->1.
  - cnt_load pulses in cycles 1, 5, 9, 13 with cnt_in 12, 6, 3, 1.
  - done=1 from cycle 13; halvings=3.
- Immediate done: init_qty=2, threshold=3, start -> DONE next cycle, cnt_load once with cnt_in=2, halvings=0, tick never asserted.
- Pause: nominal setup, pause high cycles 3-10 -> no tick during pause; first halving delayed by 8 cycles to cycle 12; qty values unchanged from nominal sequence.
- Abort and ignored start: start during RUN -> no reload; abort at cycle 6 -> IDLE at cycle 7 with cnt_load=1, cnt_in=0; later start works from scratch.
- Edge config: prescale=0, half_period=0, init_qty=15, threshold=0 -> one halving per cycle; qty 15,7,3,1,0; done after 4th halving; halvings=4.
